// File: rtl/pq_rand_stim.sv
// Random op sequencer for the priority-queue harness: turns LFSR words into enq/deq commands, occupancy-safe.
// Define PQ_STIM_DRAIN_EN to add a DRAIN state that empties the queue before signalling done.
module pq_rand_stim #(
    parameter int KW    = 16,
    parameter int VW    = 8,
    parameter int DEPTH = 15,
    parameter int OPW   = 16,
    localparam int OCW  = $clog2(DEPTH + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [OPW-1:0]     num_ops_i,
    input  logic [31:0]        rnd_i,
    output logic               rnd_enb_o,
    input  logic               pq_ready_i,
    output logic               enq_o,
    output logic               deq_o,
    output logic [KW+VW-1:0]   kv_out_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [OCW-1:0]     occupancy_o
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FIN} state_t;

    localparam logic [OCW-1:0] OCC_FULL = OCW'(DEPTH);
    localparam logic [OCW-1:0] OCC_ONE  = OCW'(1);
    localparam logic [OPW-1:0] OPS_ONE  = OPW'(1);

    state_t         state_q, state_d;
    logic [OPW-1:0] ops_left_q, ops_left_d;
    logic [OCW-1:0] occ_q, occ_d;
    logic           xfer;
    logic           unused_rnd;

    // Bits above the key/value field (except bit 31) carry no meaning here.
    assign unused_rnd = ^rnd_i;

    assign kv_out_o    = {rnd_i[KW-1:0], rnd_i[KW+VW-1:KW]};
    assign occupancy_o = occ_q;
    assign busy_o      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign done_o      = (state_q == S_FIN);

    always_comb begin
        enq_o = 1'b0;
        deq_o = 1'b0;
        case (state_q)
            S_ISSUE: begin
                // Occupancy limits override the random op select.
                if (occ_q == '0)             enq_o = 1'b1;
                else if (occ_q == OCC_FULL)  deq_o = 1'b1;
                else if (rnd_i[31])          enq_o = 1'b1;
                else                         deq_o = 1'b1;
            end
`ifdef PQ_STIM_DRAIN_EN
            S_DRAIN: deq_o = 1'b1;
`endif
            default: ;
        endcase
        xfer      = (enq_o | deq_o) & pq_ready_i;
        rnd_enb_o = xfer;
    end

    always_comb begin
        state_d    = state_q;
        ops_left_d = ops_left_q;
        occ_d      = occ_q;
        if (xfer) begin
            occ_d = enq_o ? occ_q + 1'b1 : occ_q - 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (num_ops_i != '0) begin
                        ops_left_d = num_ops_i;
                        state_d    = S_ISSUE;
                    end else begin
                        state_d = S_FIN;
                    end
                end
            end
            S_ISSUE: begin
                if (xfer) begin
                    ops_left_d = ops_left_q - 1'b1;
                    if (ops_left_q == OPS_ONE) begin
`ifdef PQ_STIM_DRAIN_EN
                        state_d = (occ_d == '0) ? S_FIN : S_DRAIN;
`else
                        state_d = S_FIN;
`endif
                    end
                end
            end
`ifdef PQ_STIM_DRAIN_EN
            S_DRAIN: begin
                if (xfer && occ_q == OCC_ONE) state_d = S_FIN;
            end
`endif
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            ops_left_q <= '0;
            occ_q      <= '0;
        end else begin
            state_q    <= state_d;
            ops_left_q <= ops_left_d;
            occ_q      <= occ_d;
        end
    end

endmodule

// File: tb/tb_pq_rand_stim.sv
// Bench for pq_rand_stim: occupancy model predicts each command, scoreboard queue holds it until the DUT transfers.
module tb_pq_rand_stim;

    localparam int DEPTH = 15;
`ifdef PQ_STIM_DRAIN_EN
    localparam bit DRAIN = 1'b1;
`else
    localparam bit DRAIN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [15:0] num_ops_i;
    logic [31:0] rnd_i;
    logic        pq_ready_i;
    logic        rnd_enb_o;
    logic        enq_o;
    logic        deq_o;
    logic [23:0] kv_out_o;
    logic        busy_o;
    logic        done_o;
    logic [3:0]  occupancy_o;

    int checks = 0;
    int errors = 0;
    int m_occ  = 0;

    typedef struct {
        logic        enq;
        logic        deq;
        logic [23:0] kv;
        bit          kvchk;
        logic [3:0]  occ;
    } exp_t;
    exp_t exp_q[$];

    pq_rand_stim dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .num_ops_i   (num_ops_i),
        .rnd_i       (rnd_i),
        .rnd_enb_o   (rnd_enb_o),
        .pq_ready_i  (pq_ready_i),
        .enq_o       (enq_o),
        .deq_o       (deq_o),
        .kv_out_o    (kv_out_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .occupancy_o (occupancy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] gen_word(input int j, input bit hi31, input bit use_fw,
                                             input logic [31:0] fw);
        logic [31:0] r;
        r = $urandom();
        if (use_fw && j == 0) return fw;
        if (hi31) r[31] = 1'b1;
        return r;
    endfunction

    function automatic void push_exp(input int j, input int n, input logic [31:0] w);
        exp_t e;
        e.kv    = {w[15:0], w[23:16]};
        e.occ   = 4'(m_occ);
        e.enq   = 1'b0;
        e.deq   = 1'b0;
        e.kvchk = 1'b1;
        if (j < n) begin
            if (m_occ == 0)          e.enq = 1'b1;
            else if (m_occ == DEPTH) e.deq = 1'b1;
            else if (w[31])          e.enq = 1'b1;
            else                     e.deq = 1'b1;
        end else if (DRAIN && n > 0 && m_occ > 0) begin
            e.deq   = 1'b1;
            e.kvchk = 1'b0;
        end else begin
            return;
        end
        m_occ = e.enq ? m_occ + 1 : m_occ - 1;
        exp_q.push_back(e);
    endfunction

    task automatic do_reset();
        @(posedge clk_i); #2;
        rst_i = 1'b1;
        #4 rst_i = 1'b0;
        m_occ = 0;
        exp_q.delete();
        @(posedge clk_i); #1;
    endtask

    task automatic run_ops(input int n, input bit hi31, input bit use_fw, input logic [31:0] fw,
                           input int stall_at, input int abort_at, input bit busy_start);
        int j = 0;
        int xfers = 0;
        int stall_left = 3;
        int cyc = 0;
        bit need_word = 1'b1;
        bit fin = 1'b0;
        exp_t e;
        logic [31:0] w;
        start_i   = 1'b1;
        num_ops_i = 16'(n);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        while (!fin && cyc < 400) begin
            cyc++;
            if (abort_at >= 0 && xfers == abort_at) begin
                #2 rst_i = 1'b1;
                #1;
                chk("abort_enq", 32'(enq_o), 32'd0);
                chk("abort_deq", 32'(deq_o), 32'd0);
                chk("abort_rnd_enb", 32'(rnd_enb_o), 32'd0);
                chk("abort_busy", 32'(busy_o), 32'd0);
                chk("abort_done", 32'(done_o), 32'd0);
                chk("abort_occ", 32'(occupancy_o), 32'd0);
                @(posedge clk_i); #1;
                rst_i = 1'b0;
                exp_q.delete();
                m_occ = 0;
                repeat (3) begin
                    @(negedge clk_i);
                    chk("abort_no_done", 32'(done_o), 32'd0);
                    chk("abort_idle", 32'(busy_o), 32'd0);
                end
                @(posedge clk_i); #1;
                return;
            end
            if (need_word) begin
                w = gen_word(j, hi31, use_fw, fw);
                rnd_i = w;
                push_exp(j, n, w);
                need_word = 1'b0;
            end
            pq_ready_i = !(stall_at >= 0 && xfers == stall_at && stall_left > 0);
            if (busy_start && cyc == 2) begin
                start_i   = 1'b1;
                num_ops_i = 16'd100;
            end
            @(negedge clk_i);
            if (exp_q.size() == 0) begin
                chk("done", 32'(done_o), 32'd1);
                chk("done_occ", 32'(occupancy_o), 32'(m_occ));
                chk("done_busy", 32'(busy_o), 32'd0);
                chk("done_enq", 32'(enq_o), 32'd0);
                chk("done_deq", 32'(deq_o), 32'd0);
                chk("done_rnd_enb", 32'(rnd_enb_o), 32'd0);
                fin = 1'b1;
                start_i   = 1'b1;
                num_ops_i = 16'd5;
                @(posedge clk_i); #1;
                start_i = 1'b0;
                @(negedge clk_i);
                chk("fin_start_ignored", 32'(busy_o), 32'd0);
                chk("done_one_cycle", 32'(done_o), 32'd0);
                chk("idle_enq", 32'(enq_o), 32'd0);
                @(posedge clk_i); #1;
            end else begin
                e = exp_q[0];
                chk("enq", 32'(enq_o), 32'(e.enq));
                chk("deq", 32'(deq_o), 32'(e.deq));
                chk("occ", 32'(occupancy_o), 32'(e.occ));
                chk("busy", 32'(busy_o), 32'd1);
                chk("no_done", 32'(done_o), 32'd0);
                chk("rnd_enb", 32'(rnd_enb_o), 32'(pq_ready_i));
                if (e.kvchk) chk("kv", 32'(kv_out_o), 32'(e.kv));
                if (pq_ready_i) begin
                    void'(exp_q.pop_front());
                    xfers++;
                    j++;
                    need_word = 1'b1;
                end else begin
                    stall_left--;
                end
                @(posedge clk_i); #1;
                start_i = 1'b0;
            end
        end
        if (!fin) chk("timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i      = 1'b0;
        start_i    = 1'b0;
        num_ops_i  = 16'd0;
        rnd_i      = 32'd0;
        pq_ready_i = 1'b1;
        #2 rst_i = 1'b1;
        #1;
        chk("rst_enq", 32'(enq_o), 32'd0);
        chk("rst_deq", 32'(deq_o), 32'd0);
        chk("rst_rnd_enb", 32'(rnd_enb_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_occ", 32'(occupancy_o), 32'd0);
        @(posedge clk_i); @(posedge clk_i); #1;
        rst_i = 1'b0;

        // single forced enqueue with a fixed word
        run_ops(1, 1'b0, 1'b1, 32'h0056_1234, -1, -1, 1'b0);
        chk("s2_occ", 32'(occupancy_o), DRAIN ? 32'd0 : 32'd1);

        // backpressure on the second op
        run_ops(4, 1'b0, 1'b0, 32'd0, 1, -1, 1'b0);

        // full boundary
        do_reset();
        run_ops(20, 1'b1, 1'b0, 32'd0, -1, -1, 1'b0);
        chk("s4_occ", 32'(occupancy_o), DRAIN ? 32'd0 : 32'd14);

        // abort after five transfers, then a fresh run
        run_ops(10, 1'b0, 1'b0, 32'd0, -1, 5, 1'b0);
        chk("abort_occ_after", 32'(occupancy_o), 32'd0);
        run_ops(6, 1'b0, 1'b0, 32'd0, -1, -1, 1'b1);

        // zero ops
        run_ops(0, 1'b0, 1'b0, 32'd0, -1, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pq_rand_stim.md
# pq_rand_stim

Random operation sequencer for the hardware priority queue test harness. It consumes words from the 32-bit enabled LFSR (`lfsr32_e`), driving that block's `enb` so the LFSR advances only when a word is used. Each consumed word becomes one enqueue (key/value) or dequeue command, presented to the priority queue under a hold-until-ready handshake. It tracks queue occupancy so it never issues an overflowing enqueue or an underflowing dequeue.

## Interface
- `KW`, 16: key width.
- `VW`, 8: value width. `KW+VW` ≤ 31; bit 31 of the random word is reserved for op select.
- `DEPTH`, 15: priority queue capacity.
- `OPW`, 16: width of the operation count.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: begins a run when idle; ignored while `busy`.
- `num_ops` in OPW: number of ops in the run; sampled on accepted `start`.
- `rnd` in 32: LFSR output `q`.
- `rnd_enb` out 1: LFSR enable; high exactly in transfer cycles.
- `pq_ready` in 1: priority queue accepts the presented op this cycle.
- `enq` out 1: enqueue command.
- `deq` out 1: dequeue command; never high together with `enq`.
- `kv_out` out KW+VW: `{key, value}`, with key = `rnd[KW-1:0]` and value = `rnd[KW+VW-1:KW]`.
- `busy` out 1: run in progress.
- `done` out 1: one-cycle pulse at end of run.
- `occupancy` out $clog2(DEPTH+1): current queue entry count.

## Operation
- FSM states: IDLE, ISSUE, DRAIN (macro only), FIN.
- **IDLE:** `enq`, `deq`, `rnd_enb` and `busy` are 0.
  - `start` with `num_ops` ≠ 0: load `ops_left`, go to ISSUE.
  - `start` with `num_ops` = 0: go to FIN.
- **ISSUE:** `busy` = 1; the op is decoded from `rnd` and `occupancy`.
  - `rnd[31]` = 1 selects enq; `rnd[31]` = 0 selects deq.
  - `occupancy` = 0 forces enq; `occupancy` = DEPTH forces deq.
- **Transfer:** `(enq|deq) & pq_ready`. On a transfer:
  - `rnd_enb` = 1.
  - `occupancy` is incremented for an enq and decremented for a deq.
  - `ops_left` is decremented.
- **Stall:** while `pq_ready` = 0, `enq`/`deq`/`kv_out` stay stable. No inputs change (`rnd` holds because `rnd_enb` = 0), so the presented op is stable.
- **End of ISSUE:** a transfer with `ops_left` = 1 goes to DRAIN (if compiled) or FIN.
- **DRAIN:** forced deq each cycle regardless of `rnd`. `kv_out` still follows `rnd`; its contents are don't-care. When `occupancy` reaches 0, go to FIN. Entering DRAIN with `occupancy` = 0 goes straight to FIN.
- **FIN:** `done` = 1 for one cycle, `busy` = 0, return to IDLE.
- `occupancy` persists across runs; only `rst` clears it.
- **Reset at any time:** asynchronously clears the state to IDLE and zeroes `ops_left`, `occupancy`, `enq`, `deq`, `rnd_enb`, `busy` and `done`. No `done` pulse is produced for the aborted run.
- `kv_out` reset value is `rnd`-derived (combinational), and is don't-care when `enq` = 0.

## Timing
- State, `ops_left` and `occupancy` are registered.
- `enq`, `deq`, `kv_out` and `rnd_enb` are combinational from those registers plus `rnd` and `pq_ready`.
- The first op is presented the cycle after `start` is accepted.
- Throughput is one op per cycle while `pq_ready` = 1.
- `done` is high in the cycle after the final transfer (or after `start` with `num_ops` = 0).
- `occupancy` reflects a transfer in the following cycle.
- `start` in the same cycle as FIN is ignored.

## Configuration
- `PQ_STIM_DRAIN_EN` defined: DRAIN state present. After `num_ops` ops, the block dequeues until `occupancy` = 0, then pulses `done`. These drain dequeues do not count toward `num_ops`.
- Undefined: no DRAIN state. `done` follows the last counted op, and `occupancy` may be nonzero at `done`.

## Test plan
All scenarios use the default parameters.

1. **Reset:** `rst` = 1 mid-clock → immediately `enq`=`deq`=`rnd_enb`=`busy`=`done`=0 and `occupancy`=0.
2. **Single forced enqueue:** `start`, `num_ops`=1, `pq_ready`=1, `rnd`=32'h0056_1234.
   - Next cycle: `enq`=1 (forced, `rnd[31]`=0), `kv_out`=24'h1234_56, `rnd_enb`=1.
   - Cycle after: `done`=1, `occupancy`=1.
   - With the drain macro: one drain deq first, then `done`, `occupancy`=0.
3. **Backpressure:** `pq_ready`=0 for 3 cycles during ISSUE → `enq`/`kv_out` held stable, `rnd_enb`=0, `occupancy` and `ops_left` unchanged. Release → the transfer completes on the first ready cycle.
4. **Full boundary:** `rnd[31]` held at 1, `num_ops`=20.
   - Ops 1–15 are enq (`occupancy` 15).
   - Op 16 is a forced deq; ops 17–20 alternate enq/deq; final `occupancy`=14.
   - Without the macro: `done` with `occupancy`=14.
   - With the macro: 14 further deqs, then `done` with `occupancy`=0.
5. **Abort:** `rst` asserted after 5 transfers → all outputs 0, `occupancy`=0, no `done`. A fresh `start` works normally.
6. **Zero ops:** `start` with `num_ops`=0 → no `enq`/`deq`/`rnd_enb`, `done`=1 exactly one cycle later. A `start` while `busy`=1 is ignored and does not change `ops_left`.
